// File: rtl/hub75_bcm_driver.sv
// HUB75 row driver: shifts BITS_PER_COLOR bit-planes LSB-first and shows each for BASE_PERIOD<<plane.
// Optional feature macro: HUB75_GLOBAL_BRIGHTNESS_EN adds brightness_in to shorten the lit window.
module hub75_bcm_driver #(
    parameter int unsigned NUM_COLS       = 64,
    parameter int unsigned SCAN_RATE      = 32,
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned BITS_PER_COLOR = 3,
    parameter int unsigned BASE_PERIOD    = 100,
    parameter int unsigned BLANK_CYCLES   = 2
) (
    input  logic                                                     clk_in,
    input  logic                                                     rst_n_in,
    input  logic [CHANNELS-1:0][NUM_COLS-1:0][3*BITS_PER_COLOR-1:0] column_data,
    input  logic [$clog2(SCAN_RATE)-1:0]                             address_data,
    input  logic                                                     tvalid,
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
    input  logic [7:0]                                               brightness_in,
`endif
    output logic                                                     tready,
    output logic                                                     tlast,
    output logic [CHANNELS-1:0][2:0]                                 rgb_out,
    output logic                                                     led_clk,
    output logic                                                     led_latch,
    output logic                                                     led_output_enable,
    output logic [$clog2(SCAN_RATE)-1:0]                             hub75_address
);
    localparam int unsigned AW     = $clog2(SCAN_RATE);
    localparam int unsigned ColW   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned PlaneW = (BITS_PER_COLOR > 1) ? $clog2(BITS_PER_COLOR) : 1;
    localparam int unsigned MaxLen = BASE_PERIOD << (BITS_PER_COLOR - 1);
    localparam int unsigned CntW   = $clog2((MaxLen > BLANK_CYCLES) ? MaxLen : BLANK_CYCLES) + 1;
    localparam int unsigned PixW   = 3 * BITS_PER_COLOR;

    typedef enum logic [2:0] {StIdle, StShift, StBlank, StLatch, StDisplay} state_e;

    state_e            state_q, state_d;
    logic [ColW-1:0]   col_q, col_d;
    logic              phase_q, phase_d;
    logic [PlaneW-1:0] plane_q, plane_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   len_q, len_d, on_len;
    logic              accept;

    logic [CHANNELS-1:0][NUM_COLS-1:0][PixW-1:0] data_q, data_sel;
    logic [AW-1:0]                               addr_q;
    logic [CHANNELS-1:0][2:0]                    shift_bits;

    logic [CHANNELS-1:0][2:0] rgb_q, rgb_d;
    logic                     led_clk_q, led_clk_d;
    logic                     latch_q, latch_d;
    logic                     oe_q, oe_d;
    logic                     tlast_q, tlast_d;
    logic [AW-1:0]            haddr_q, haddr_d;

    assign tready   = (state_q == StIdle);
    assign accept   = tvalid && tready;
    // The first shifted pixel is taken straight from the bus on the accept cycle.
    assign data_sel = (state_q == StIdle) ? column_data : data_q;
    assign len_q    = CntW'(BASE_PERIOD) << plane_q;
    assign len_d    = CntW'(BASE_PERIOD) << plane_d;

`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
    logic [7:0] bright_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bright_q <= '0;
        end else if (accept) begin
            bright_q <= brightness_in;
        end
    end

    assign on_len = CntW'(({8'd0, len_d} * {{CntW{1'b0}}, bright_q}) >> 8);
`else
    assign on_len = len_d;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        for (genvar k = 0; k < 3; k++) begin : g_comp
            logic [BITS_PER_COLOR-1:0] comp;
            assign comp             = data_sel[c][col_d][k*BITS_PER_COLOR +: BITS_PER_COLOR];
            assign shift_bits[c][k] = comp[plane_d];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_q <= '0;
            addr_q <= '0;
        end else if (accept) begin
            data_q <= column_data;
            addr_q <= address_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            col_q   <= '0;
            phase_q <= 1'b0;
            plane_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            phase_q <= phase_d;
            plane_q <= plane_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        phase_d = phase_q;
        plane_d = plane_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (tvalid) begin
                    state_d = StShift;
                    col_d   = '0;
                    phase_d = 1'b0;
                    plane_d = '0;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (col_q == ColW'(NUM_COLS - 1)) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StBlank: begin
                if (cnt_q == CntW'(BLANK_CYCLES - 1)) begin
                    state_d = StLatch;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLatch: begin
                state_d = StDisplay;
                cnt_d   = '0;
            end
            StDisplay: begin
                if (cnt_q == len_q - 1'b1) begin
                    cnt_d = '0;
                    if (plane_q == PlaneW'(BITS_PER_COLOR - 1)) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StShift;
                        plane_d = plane_q + 1'b1;
                        col_d   = '0;
                        phase_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from next-state values so the registered pins line up with the state.
    always_comb begin
        rgb_d     = rgb_q;
        haddr_d   = haddr_q;
        led_clk_d = (state_d == StShift) && phase_d;
        latch_d   = (state_d == StLatch);
        oe_d      = !((state_d == StDisplay) && (cnt_d < on_len));
        tlast_d   = (state_d == StDisplay) && (plane_d == PlaneW'(BITS_PER_COLOR - 1)) &&
                    (cnt_d == len_d - 1'b1);
        if ((state_d == StShift) && !phase_d) begin
            rgb_d = shift_bits;
        end
        if ((state_d == StBlank) && (state_q != StBlank) && (plane_d == '0)) begin
            haddr_d = addr_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rgb_q     <= '0;
            led_clk_q <= 1'b0;
            latch_q   <= 1'b0;
            oe_q      <= 1'b1;
            tlast_q   <= 1'b0;
            haddr_q   <= '0;
        end else begin
            rgb_q     <= rgb_d;
            led_clk_q <= led_clk_d;
            latch_q   <= latch_d;
            oe_q      <= oe_d;
            tlast_q   <= tlast_d;
            haddr_q   <= haddr_d;
        end
    end

    assign rgb_out           = rgb_q;
    assign led_clk           = led_clk_q;
    assign led_latch         = latch_q;
    assign led_output_enable = oe_q;
    assign tlast             = tlast_q;
    assign hub75_address     = haddr_q;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Bench for hub75_bcm_driver: random rows compared cycle by cycle against a schedule model
// built from the row timing rules (plane loop of shift / blank / latch / display windows).
`timescale 1ns/1ps
module tb_hub75_bcm_driver;
    localparam int NumCols = 4;
    localparam int Ch      = 2;
    localparam int B       = 3;
    localparam int Bp      = 2;
    localparam int Bl      = 2;
    localparam int Row     = B * (2 * NumCols + Bl + 1) + Bp * ((1 << B) - 1);
    localparam int Row1    = 2 * NumCols + Bl + 1 + 1;
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
    localparam int BrFull  = 255;
`else
    localparam int BrFull  = 256;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [Ch-1:0][NumCols-1:0][3*B-1:0] col_data;
    logic [1:0]                          addr_in;
    logic                                tvalid, tready, tlast, led_clk, led_latch, oe;
    logic [Ch-1:0][2:0]                  rgb;
    logic [1:0]                          haddr;
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
    logic [7:0]                          bright;
`endif

    logic [Ch-1:0][NumCols-1:0][2:0]     col_data1;
    logic [1:0]                          addr1;
    logic                                tvalid1, tready1, tlast1, led_clk1, latch1, oe1;
    logic [Ch-1:0][2:0]                  rgb1;
    logic [1:0]                          haddr1;

    hub75_bcm_driver #(
        .NUM_COLS(NumCols), .SCAN_RATE(4), .CHANNELS(Ch), .BITS_PER_COLOR(B),
        .BASE_PERIOD(Bp), .BLANK_CYCLES(Bl)
    ) u_dut (
        .clk_in(clk), .rst_n_in(rst_n), .column_data(col_data), .address_data(addr_in),
        .tvalid(tvalid),
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
        .brightness_in(bright),
`endif
        .tready(tready), .tlast(tlast), .rgb_out(rgb), .led_clk(led_clk),
        .led_latch(led_latch), .led_output_enable(oe), .hub75_address(haddr)
    );

    hub75_bcm_driver #(
        .NUM_COLS(NumCols), .SCAN_RATE(4), .CHANNELS(Ch), .BITS_PER_COLOR(1),
        .BASE_PERIOD(1), .BLANK_CYCLES(Bl)
    ) u_dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .column_data(col_data1), .address_data(addr1),
        .tvalid(tvalid1),
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
        .brightness_in(8'd255),
`endif
        .tready(tready1), .tlast(tlast1), .rgb_out(rgb1), .led_clk(led_clk1),
        .led_latch(latch1), .led_output_enable(oe1), .hub75_address(haddr1)
    );

    int total = 0;
    int bad   = 0;

    int         pix[Ch][NumCols];
    int         pix1[Ch][NumCols];
    logic [1:0] prev_addr, prev1;
    // Expected {tready, led_clk, led_latch, oe, tlast, addr} per cycle after accept.
    logic [6:0] exp_ctl[Row];
    logic [5:0] exp_rgb[Row];
    bit         exp_shift[Row];

    function automatic int pick_br();
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
        return int'($urandom_range(0, 255));
`else
        return 256;
`endif
    endfunction

    task automatic build_model(input logic [1:0] a, input int br);
        int i = 0;
        int len, on, r, g, bb;
        logic [5:0] v;
        for (int p = 0; p < B; p++) begin
            len = Bp << p;
            on  = (len * br) >> 8;
            for (int col = 0; col < NumCols; col++) begin
                v = '0;
                for (int c = 0; c < Ch; c++) begin
                    r  = (pix[c][col] >> p) & 1;
                    g  = (pix[c][col] >> (B + p)) & 1;
                    bb = (pix[c][col] >> (2 * B + p)) & 1;
                    v  = v | 6'((bb * 4 + g * 2 + r) << (3 * c));
                end
                for (int ph = 0; ph < 2; ph++) begin
                    exp_ctl[i]   = {1'b0, 1'(ph), 1'b0, 1'b1, 1'b0, (p == 0) ? prev_addr : a};
                    exp_rgb[i]   = v;
                    exp_shift[i] = 1'b1;
                    i++;
                end
            end
            for (int k = 0; k < Bl; k++) begin
                exp_ctl[i] = {5'b00010, a};
                exp_shift[i] = 1'b0;
                i++;
            end
            exp_ctl[i] = {5'b00110, a};
            exp_shift[i] = 1'b0;
            i++;
            for (int k = 0; k < len; k++) begin
                exp_ctl[i]   = {3'b000, k >= on, (p == B - 1) && (k == len - 1), a};
                exp_shift[i] = 1'b0;
                i++;
            end
        end
    endtask

    // Starts and checks one row; expects to be called on a negedge with the driver idle.
    task automatic run_row(input logic [1:0] a, input int br, input bit keep, input bit force_px);
        logic [Ch*NumCols*3*B-1:0] flat = '0;
        for (int c = 0; c < Ch; c++) begin
            for (int col = 0; col < NumCols; col++) begin
                pix[c][col] = int'($urandom_range(0, 511));
                if (force_px && c == 0 && col == 0) pix[c][col] = (pix[c][col] & ~7) | 5;
                flat = flat | ((Ch*NumCols*3*B)'(pix[c][col]) << ((c * NumCols + col) * 3 * B));
            end
        end
        build_model(a, br);
        col_data = flat;
        addr_in  = a;
        tvalid   = 1'b1;
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
        bright   = 8'(br);
`endif
        total++;
        if (tready !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready got=%b exp=1", tready);
        end
        for (int i = 0; i < Row; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (!keep) tvalid = 1'b0;
                col_data = ~col_data;
                addr_in  = ~addr_in;
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
                bright   = ~bright;
`endif
            end
            total++;
            if ({tready, led_clk, led_latch, oe, tlast, haddr} !== exp_ctl[i]) begin
                bad++;
                $display("FAIL row_ctl cyc=%0d got=%b exp=%b", i,
                         {tready, led_clk, led_latch, oe, tlast, haddr}, exp_ctl[i]);
            end
            if (exp_shift[i]) begin
                total++;
                if (rgb !== exp_rgb[i]) begin
                    bad++;
                    $display("FAIL row_rgb cyc=%0d got=%b exp=%b", i, rgb, exp_rgb[i]);
                end
            end
        end
        @(negedge clk);
        total++;
        if ({tready, led_clk, led_latch, oe, tlast, haddr} !== {5'b10010, a}) begin
            bad++;
            $display("FAIL row_idle got=%b exp=%b", {tready, led_clk, led_latch, oe, tlast, haddr},
                     {5'b10010, a});
        end
        prev_addr = a;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({led_clk, led_latch, oe, tlast, haddr, rgb} !== {6'b001000, 6'd0}) begin
            bad++;
            $display("FAIL reset_state got=%b exp=%b", {led_clk, led_latch, oe, tlast, haddr, rgb},
                     {6'b001000, 6'd0});
        end
        total++;
        if ({led_clk1, latch1, oe1, tlast1, haddr1} !== 6'b001000) begin
            bad++;
            $display("FAIL reset_state1 got=%b exp=001000", {led_clk1, latch1, oe1, tlast1, haddr1});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({tready, tready1, oe} !== 3'b111) begin
            bad++;
            $display("FAIL reset_release got=%b exp=111", {tready, tready1, oe});
        end
    endtask

    task automatic test_single_row();
        run_row(2'd3, BrFull, 1'b0, 1'b1);
    endtask

    task automatic test_random_rows();
        for (int n = 0; n < 4; n++) begin
            run_row(2'($urandom_range(0, 3)), pick_br(), 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) run_row(2'($urandom_range(0, 3)), pick_br(), 1'b1, 1'b0);
        run_row(2'($urandom_range(0, 3)), pick_br(), 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_display();
        col_data = '1;
        addr_in  = 2'd2;
        tvalid   = 1'b1;
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
        bright   = 8'd255;
`endif
        for (int i = 0; i < 2 * NumCols + Bl + 2; i++) begin
            @(negedge clk);
            if (i == 0) tvalid = 1'b0;
        end
        total++;
        if ({oe, haddr} !== 3'b010) begin
            bad++;
            $display("FAIL pre_reset_display got=%b exp=010", {oe, haddr});
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({led_clk, led_latch, oe, tlast, haddr} !== 6'b001000) begin
            bad++;
            $display("FAIL reset_async got=%b exp=001000", {led_clk, led_latch, oe, tlast, haddr});
        end
        @(negedge clk);
        rst_n     = 1'b1;
        prev_addr = 2'd0;
        prev1     = 2'd0;
        @(negedge clk);
        total++;
        if ({tready, oe, led_clk, haddr} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_recover got=%b exp=11000", {tready, oe, led_clk, haddr});
        end
        run_row(2'd1, pick_br(), 1'b0, 1'b0);
    endtask

`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
    task automatic test_brightness();
        run_row(2'd1, 128, 1'b0, 1'b0);
        run_row(2'd2, 0, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_single_plane(input logic [1:0] a);
        logic [Ch*NumCols*3-1:0] flat = '0;
        logic [6:0] ex;
        int on1 = BrFull >> 8;
        for (int c = 0; c < Ch; c++) begin
            for (int col = 0; col < NumCols; col++) begin
                pix1[c][col] = int'($urandom_range(0, 7));
                flat = flat | ((Ch*NumCols*3)'(pix1[c][col]) << ((c * NumCols + col) * 3));
            end
        end
        col_data1 = flat;
        addr1     = a;
        tvalid1   = 1'b1;
        total++;
        if (tready1 !== 1'b1) begin
            bad++;
            $display("FAIL b1_accept_ready got=%b exp=1", tready1);
        end
        for (int i = 0; i < Row1; i++) begin
            @(negedge clk);
            if (i == 0) begin
                tvalid1   = 1'b0;
                col_data1 = ~col_data1;
            end
            ex = {1'b0, (i < 2 * NumCols) ? 1'(i % 2) : 1'b0, i == Row1 - 2,
                  !(i == Row1 - 1 && on1 > 0), i == Row1 - 1, (i < 2 * NumCols) ? prev1 : a};
            total++;
            if ({tready1, led_clk1, latch1, oe1, tlast1, haddr1} !== ex) begin
                bad++;
                $display("FAIL b1_ctl cyc=%0d got=%b exp=%b", i,
                         {tready1, led_clk1, latch1, oe1, tlast1, haddr1}, ex);
            end
            if (i < 2 * NumCols) begin
                total++;
                if (rgb1 !== {3'(pix1[1][i / 2]), 3'(pix1[0][i / 2])}) begin
                    bad++;
                    $display("FAIL b1_rgb cyc=%0d got=%b exp=%b", i, rgb1,
                             {3'(pix1[1][i / 2]), 3'(pix1[0][i / 2])});
                end
            end
        end
        @(negedge clk);
        total++;
        if ({tready1, oe1, tlast1, latch1} !== 4'b1100) begin
            bad++;
            $display("FAIL b1_idle got=%b exp=1100", {tready1, oe1, tlast1, latch1});
        end
        prev1 = a;
    endtask

    initial begin
        rst_n     = 1'b1;
        tvalid    = 1'b0;
        col_data  = '0;
        addr_in   = '0;
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
        bright    = '0;
`endif
        tvalid1   = 1'b0;
        col_data1 = '0;
        addr1     = '0;
        prev_addr = '0;
        prev1     = '0;
        test_reset();
        test_single_row();
        test_random_rows();
        test_back_to_back();
        test_reset_mid_display();
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
        test_brightness();
`endif
        test_single_plane(2'd3);
        test_single_plane(2'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
